// File: rtl/adc_sample_reader.sv
// Wishbone-slave reader for the SAR ADC result stream. It captures one sample per
// rising edge of adc_valid into a FIFO, keeps a sample total and raises a fill-level irq.
module adc_sample_reader #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          RES_W    = 10,
  parameter int          DEPTH    = 16,
  parameter int          AW       = $clog2(DEPTH)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [RES_W-1:0] adc_result,
  input  logic             adc_valid,
  output logic             adc_en,
  output logic             adc_cal,
  output logic             irq
);

  localparam logic [AW:0] FULL_CNT   = DEPTH[AW:0];
  localparam logic [AW:0] THRESH_RST = FULL_CNT >> 1;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_DATA   = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_THRESH = 3'd4;

  logic [RES_W-1:0] mem_q [DEPTH];

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             en_q, en_d;
  logic             cal_q, cal_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic             valid_q;
  logic             overflow_q, overflow_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      thresh_q, thresh_d;
  logic [31:0]      samples_q, samples_d;

  logic             in_window;
  logic             req;
  logic [2:0]       reg_idx;
  logic             rd_en;
  logic             wr_en;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             clr;
  logic             push_req;
  logic             push;
  logic             drop;
  logic [31:0]      rdata;
  logic [31:0]      status_word;
  logic [31:0]      data_word;

  // Upper sel/data bits and the byte offset are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i};

  assign in_window  = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign req        = wbs_stb_i & wbs_cyc_i & ~ack_q & in_window;
  assign reg_idx    = wbs_adr_i[4:2];
  assign rd_en      = req & ~wbs_we_i;
  assign wr_en      = req & wbs_we_i & wbs_sel_i[0];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = rd_en & (reg_idx == OFF_DATA) & ~fifo_empty;
  assign clr        = wr_en & (reg_idx == OFF_CTRL) & wbs_dat_i[3];

  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push_req   = adc_valid & ~valid_q & en_q;
  assign push       = push_req & ~clr & (~fifo_full | pop);
  assign drop       = push_req & ~clr & fifo_full & ~pop;

  always_comb begin
    status_word              = '0;
    status_word[0]           = fifo_empty;
    status_word[1]           = fifo_full;
    status_word[2]           = overflow_q;
    status_word[8+AW:8]      = count_q;

    data_word                = '0;
    data_word[RES_W-1:0]     = mem_q[rptr_q];
    data_word[31]            = 1'b1;

    rdata = '0;
    case (reg_idx)
      OFF_CTRL:   rdata = {28'b0, 1'b0, irq_en_q, cal_q, en_q};
      OFF_STATUS: rdata = status_word;
      OFF_DATA:   rdata = fifo_empty ? 32'b0 : data_word;
      OFF_COUNT:  rdata = samples_q;
      OFF_THRESH: rdata = {{(31-AW){1'b0}}, thresh_q};
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    ack_d      = req;
    dat_d      = rd_en ? rdata : 32'b0;
    en_d       = en_q;
    cal_d      = cal_q;
    irq_en_d   = irq_en_q;
    thresh_d   = thresh_q;
    overflow_d = overflow_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    samples_d  = samples_q + {31'b0, push};
    irq_d      = irq_en_q & (count_q >= thresh_q);

    if (wr_en && reg_idx == OFF_CTRL) begin
      en_d     = wbs_dat_i[0];
      cal_d    = wbs_dat_i[1];
      irq_en_d = wbs_dat_i[2];
    end

    if (wr_en && reg_idx == OFF_THRESH) begin
      thresh_d = (wbs_dat_i[AW:0] == '0) ? {{AW{1'b0}}, 1'b1} : wbs_dat_i[AW:0];
    end

    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // A drop on the same edge as a W1C leaves the flag set.
      if (drop) begin
        overflow_d = 1'b1;
      end else if (wr_en && reg_idx == OFF_STATUS && wbs_dat_i[2]) begin
        overflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      en_q       <= 1'b0;
      cal_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      thresh_q   <= THRESH_RST;
      samples_q  <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      en_q       <= en_d;
      cal_q      <= cal_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      valid_q    <= adc_valid;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      thresh_q   <= thresh_d;
      samples_q  <= samples_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wptr_q] <= adc_result;
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign adc_en    = en_q;
  assign adc_cal   = cal_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_adc_sample_reader.sv
// Directed bench for adc_sample_reader: register access, capture, overflow,
// simultaneous FIFO events and the fill-level interrupt.
module tb_adc_sample_reader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_i = '0;
  logic [31:0] adr = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [9:0]  adc_result = '0;
  logic        adc_valid = 1'b0;
  logic        adc_en;
  logic        adc_cal;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_sample_reader dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_dat_i  (dat_i),
    .wbs_adr_i  (adr),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .adc_result (adc_result),
    .adc_valid  (adc_valid),
    .adc_en     (adc_en),
    .adc_cal    (adc_cal),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic got, output logic [31:0] rd);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    got = 1'b0; rd = '0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; rd = dat_o; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [31:0] off, input logic [31:0] exp, input string tag);
    logic got; logic [31:0] v;
    wb_access(BASE + off, 1'b0, 32'h0, 4'hF, got, v);
    chk({tag, "_ack"}, {31'b0, got}, 32'h1);
    chk(tag, v, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s, input string tag);
    logic got; logic [31:0] v;
    wb_access(BASE + off, 1'b1, d, s, got, v);
    chk({tag, "_ack"}, {31'b0, got}, 32'h1);
  endtask

  task automatic adc_edge(input logic [9:0] v);
    @(negedge clk); adc_valid = 1'b1; adc_result = v;
    @(negedge clk); adc_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_outs", {29'b0, adc_en, adc_cal, irq}, 32'h0);
    rd_chk(32'h00, 32'h0, "rst_ctrl");
    rd_chk(32'h04, 32'h1, "rst_status");
    rd_chk(32'h08, 32'h0, "rst_data");
    rd_chk(32'h0C, 32'h0, "rst_count");
    rd_chk(32'h10, 32'h8, "rst_thresh");
    rd_chk(32'h14, 32'h0, "unused_off");
    chk("dat_idle", dat_o, 32'h0);

    wr(32'h00, 32'h3, 4'hF, "ctrl_encal");
    chk("cal_on", {30'b0, adc_en, adc_cal}, 32'h3);
    wr(32'h00, 32'h1, 4'hF, "ctrl_en");
    wr(32'h00, 32'h0, 4'hE, "ctrl_nosel");
    chk("nosel_keep", {30'b0, adc_en, adc_cal}, 32'h2);
    adc_edge(10'h155);
    adc_edge(10'h2AA);
    adc_edge(10'h3FF);
    rd_chk(32'h04, 32'h300, "st_cnt3");
    rd_chk(32'h08, 32'h8000_0155, "data0");
    rd_chk(32'h08, 32'h8000_02AA, "data1");
    rd_chk(32'h08, 32'h8000_03FF, "data2");
    rd_chk(32'h08, 32'h0, "data_empty");
    rd_chk(32'h0C, 32'h3, "count3");

    @(negedge clk); adc_valid = 1'b1; adc_result = 10'h0AB;
    repeat (20) @(negedge clk);
    adc_valid = 1'b0;
    @(posedge clk); #1;
    rd_chk(32'h04, 32'h100, "hold_one");
    rd_chk(32'h0C, 32'h4, "hold_count");
    rd_chk(32'h08, 32'h8000_00AB, "hold_data");
    wr(32'h00, 32'h0, 4'hF, "ctrl_off");
    adc_edge(10'h111);
    rd_chk(32'h04, 32'h1, "en0_nopush");
    rd_chk(32'h0C, 32'h4, "en0_count");

    wr(32'h00, 32'h1, 4'hF, "ctrl_en2");
    for (int i = 0; i < 18; i++) adc_edge(10'h020 + 10'(i));
    rd_chk(32'h04, 32'h1006, "st_full_ovf");
    rd_chk(32'h0C, 32'd20, "count20");
    wr(32'h04, 32'h4, 4'hF, "w1c");
    rd_chk(32'h04, 32'h1002, "st_w1c");

    // DATA read on a full FIFO on the same edge as a new sample
    @(negedge clk);
    adc_valid = 1'b1; adc_result = 10'h3CC;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h08; sel = 4'hF;
    @(posedge clk); #1;
    chk("pp_ack", {31'b0, ack}, 32'h1);
    chk("pp_data", dat_o, 32'h8000_0020);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk); adc_valid = 1'b0;
    @(posedge clk); #1;
    rd_chk(32'h04, 32'h1002, "pp_status");
    rd_chk(32'h0C, 32'd21, "pp_count");
    rd_chk(32'h08, 32'h8000_0021, "pp_next");

    // fifo_clr on the same edge as a new sample
    @(negedge clk);
    adc_valid = 1'b1; adc_result = 10'h1E1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; dat_i = 32'h9; sel = 4'hF;
    @(posedge clk); #1;
    chk("clr_ack", {31'b0, ack}, 32'h1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk); adc_valid = 1'b0;
    @(posedge clk); #1;
    rd_chk(32'h04, 32'h1, "clr_status");
    rd_chk(32'h0C, 32'd21, "clr_count");
    rd_chk(32'h00, 32'h1, "clr_ctrl");

    wr(32'h10, 32'h0, 4'hF, "th0");
    rd_chk(32'h10, 32'h1, "th0_as1");
    wr(32'h10, 32'h4, 4'hF, "th4");
    rd_chk(32'h10, 32'h4, "th4_rb");
    wr(32'h00, 32'h5, 4'hF, "ctrl_irq");
    chk("irq_idle", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 3; i++) adc_edge(10'h040 + 10'(i));
    @(negedge clk); adc_valid = 1'b1; adc_result = 10'h043;
    @(posedge clk); #1;
    chk("irq_pushcyc", {31'b0, irq}, 32'h0);
    @(negedge clk); adc_valid = 1'b0;
    @(posedge clk); #1;
    chk("irq_rise", {31'b0, irq}, 32'h1);
    rd_chk(32'h08, 32'h8000_0040, "irq_pop");
    chk("irq_fall", {31'b0, irq}, 32'h0);

    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h20; sel = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0;
    chk("oow_noack", {31'b0, seen}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
